// File: rtl/inv_cipher_ctrl.sv
// AES-128 inverse cipher controller: iterative decryption, one inverse round per clock,
// with round keys read combinationally from an external key store.
module inv_cipher_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]   state_r;
    logic [1:0]   state_nxt_s;
    logic [127:0] data_r;
    logic [127:0] data_nxt_s;
    logic [3:0]   round_r;
    logic [3:0]   round_nxt_s;
    logic [127:0] sr_sb_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^127 by repeated square-and-multiply, then one square).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127 - 8*(rw + 4*c) -: 8] = s[127 - 8*(rw + 4*((c - rw + 4) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = 128'd0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

    assign sr_sb_s   = inv_sub_bytes(inv_shift_rows(data_r));
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign out_block = (state_r == ST_DONE) ? data_r : 128'd0;

    // Round-key index: the last key is presented while idle so the initial AddRoundKey is same-cycle.
    always_comb begin
        case (state_r)
            ST_IDLE:  rk_addr = 4'd10;
            ST_ROUND: rk_addr = round_r;
            ST_FINAL: rk_addr = 4'd0;
            ST_DONE:  rk_addr = 4'd10;
            default:  rk_addr = 4'd10;
        endcase
    end

    // Next-state, datapath and round-counter decode.
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = data_r;
        round_nxt_s = round_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_ROUND;
                    data_nxt_s  = in_block ^ rk_data;
                    round_nxt_s = 4'd9;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                data_nxt_s = inv_mix_columns(sr_sb_s ^ rk_data);
                if (round_r == 4'd1) begin
                    state_nxt_s = ST_FINAL;
                end else begin
                    round_nxt_s = round_r - 4'd1;
                end
            end
            ST_FINAL: begin
                data_nxt_s  = sr_sb_s ^ rk_data;
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                data_nxt_s  = 128'd0;
                round_nxt_s = 4'd0;
            end
        endcase
    end

    // State, datapath and round registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            data_r  <= 128'd0;
            round_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            data_r  <= data_nxt_s;
            round_r <= round_nxt_s;
        end
    end

endmodule
